// File: rtl/rt_cross_clk_arb.sv
// rt_cross_clk_arb: round-robin sequencer sharing one data-enable
// clock-crossing channel, with busy watchdog and issue counter.
module rt_cross_clk_arb #(
   parameter int NREQ    = 4,
   parameter int DWIDTH  = 8,
   parameter int TAGW    = 2,
   parameter int TMO_CYC = 1024,
   parameter int CNTW    = 16
) (
   input  logic                   rt_i_aclk,
   input  logic                   rt_i_rst_aclk,
   input  logic [NREQ-1:0]        rt_i_req_aclk,
   input  logic [NREQ*DWIDTH-1:0] rt_i_din_aclk,
   output logic [NREQ-1:0]        rt_o_ack_aclk,
   output logic                   rt_o_de_aclk,
   output logic [TAGW+DWIDTH-1:0] rt_o_din_aclk,
   input  logic                   rt_i_busy_aclk,
   input  logic                   rt_i_err_clr_aclk,
   output logic                   rt_o_err_aclk,
   output logic [CNTW-1:0]        rt_o_xfer_cnt_aclk
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SENT,
      ST_WAIT
   } state_t;

   state_t            state;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     win;
   logic              found;
   logic [TW-1:0]     tmo;
   logic [DWIDTH-1:0] pay [NREQ];
   logic [DWIDTH-1:0] win_pay;
   int                j;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         pay[i] = rt_i_din_aclk[i*DWIDTH +: DWIDTH];
      end
   end

   // First requester after the last winner, wrapping around.
   always_comb begin
      found   = 1'b0;
      win     = ptr;
      win_pay = '0;
      j       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && rt_i_req_aclk[j[PW-1:0]]) begin
            found   = 1'b1;
            win     = j[PW-1:0];
            win_pay = pay[j[PW-1:0]];
         end
      end
   end

   always_ff @(posedge rt_i_aclk) begin
      if (rt_i_rst_aclk) begin
         state              <= ST_IDLE;
         ptr                <= PW'(NREQ - 1);
         tmo                <= '0;
         rt_o_ack_aclk      <= '0;
         rt_o_de_aclk       <= 1'b0;
         rt_o_din_aclk      <= '0;
         rt_o_err_aclk      <= 1'b0;
         rt_o_xfer_cnt_aclk <= '0;
      end else begin
         rt_o_ack_aclk <= '0;
         rt_o_de_aclk  <= 1'b0;
         if (rt_i_err_clr_aclk) begin
            rt_o_err_aclk <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (found && !rt_i_busy_aclk) begin
                  rt_o_de_aclk       <= 1'b1;
                  rt_o_ack_aclk[win] <= 1'b1;
                  rt_o_din_aclk      <= {TAGW'(win), win_pay};
                  ptr                <= win;
                  rt_o_xfer_cnt_aclk <= rt_o_xfer_cnt_aclk + CNTW'(1);
                  state              <= ST_SENT;
               end
            end
            ST_SENT: begin
               tmo   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!rt_i_busy_aclk) begin
                  state <= ST_IDLE;
               end else if (tmo == TMO_LAST) begin
                  // Later assignment overrides a same-cycle clear.
                  rt_o_err_aclk <= 1'b1;
                  state         <= ST_IDLE;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rt_cross_clk_arb.sv
// tb_rt_cross_clk_arb: randomized stimulus against a cycle-indexed
// reference of the arbiter's issue rules.
module tb_rt_cross_clk_arb;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int TAGW = 2;
   localparam int TMO  = 8;
   localparam int CNTW = 4;
   localparam int NCYC = 3000;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ*DW-1:0]     din;
   logic [NREQ-1:0]        ack;
   logic                   de;
   logic [TAGW+DW-1:0]     dout;
   logic                   busy;
   logic                   clr;
   logic                   err;
   logic [CNTW-1:0]        cnt;

   rt_cross_clk_arb #(
      .NREQ    (NREQ),
      .DWIDTH  (DW),
      .TAGW    (TAGW),
      .TMO_CYC (TMO),
      .CNTW    (CNTW)
   ) u_dut (
      .rt_i_aclk          (clk),
      .rt_i_rst_aclk      (rst),
      .rt_i_req_aclk      (req),
      .rt_i_din_aclk      (din),
      .rt_o_ack_aclk      (ack),
      .rt_o_de_aclk       (de),
      .rt_o_din_aclk      (dout),
      .rt_i_busy_aclk     (busy),
      .rt_i_err_clr_aclk  (clr),
      .rt_o_err_aclk      (err),
      .rt_o_xfer_cnt_aclk (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  tag, $time, got, exp);
      end
   endtask

   // Reference state: edges are numbered; after an issue at edge t
   // the channel is off limits until busy is seen low at edge t+2 or
   // later, or until TMO waiting edges have elapsed with busy high.
   int          edge_n = 0;
   int          t_iss = 0;
   bit          blocked = 0;
   int          m_ptr = NREQ - 1;
   bit          m_err = 0;
   int          m_cnt = 0;
   bit          e_de = 0;
   logic [3:0]  e_ack = '0;
   logic [9:0]  e_din = '0;
   logic [7:0]  pay [NREQ];

   task automatic model_step();
      int best;
      int bestd;
      int d;
      edge_n++;
      e_de  = 0;
      e_ack = '0;
      if (rst) begin
         blocked = 0;
         m_ptr   = NREQ - 1;
         m_err   = 0;
         m_cnt   = 0;
         e_din   = '0;
         return;
      end
      if (clr) m_err = 0;
      if (blocked) begin
         if (edge_n >= t_iss + 2) begin
            if (!busy) blocked = 0;
            else if (edge_n - t_iss - 2 == TMO - 1) begin
               m_err   = 1;
               blocked = 0;
            end
         end
      end else if (req != 0 && !busy) begin
         best  = -1;
         bestd = NREQ;
         for (int i = 0; i < NREQ; i++) begin
            d = (i - m_ptr - 1 + 2 * NREQ) % NREQ;
            if (req[i] && d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
         e_de        = 1;
         e_ack[best] = 1'b1;
         e_din       = {2'(best), pay[best]};
         m_ptr       = best;
         m_cnt       = (m_cnt + 1) % (1 << CNTW);
         blocked     = 1;
         t_iss       = edge_n;
      end
   endtask

   int bleft = 0;
   int blen  = 5;

   task automatic drive(input int c);
      rst = (c < 3) || (c > 300 && $urandom_range(299) == 0);
      clr = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (e_ack[i]) begin
            req[i] = ($urandom_range(1) == 1);
            pay[i] = 8'($urandom);
         end else if (!req[i]) begin
            if ($urandom_range(3) == 0) begin
               req[i] = 1'b1;
               pay[i] = 8'($urandom);
            end
         end else if ($urandom_range(40) == 0) begin
            req[i] = 1'b0;
         end
      end
      if (c < 60) begin
         req    = req & 4'b0001;
         pay[0] = 8'hA5;
         blen   = 5;
      end else if (c < 120) begin
         req  = 4'b1111;
         blen = 4;
      end else if (c < 180) begin
         req  = 4'b1010;
         blen = 4;
      end else if (c < 260) begin
         blen = 20;
         clr  = (c >= 230);
      end else begin
         blen = $urandom_range(12);
         clr  = ($urandom_range(19) == 0);
      end
      din = {pay[3], pay[2], pay[1], pay[0]};
      if (e_de) bleft = blen;
      busy = (bleft > 0);
      if (bleft > 0) bleft--;
      else if (c >= 260 && $urandom_range(15) == 0) busy = 1'b1;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      din  = '0;
      busy = 1'b0;
      clr  = 1'b0;
      for (int i = 0; i < NREQ; i++) pay[i] = '0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         drive(c);
         @(posedge clk);
         model_step();
         #1;
         chk("de", 32'(de), 32'(e_de));
         chk("ack", 32'(ack), 32'(e_ack));
         chk("din", 32'(dout), 32'(e_din));
         chk("err", 32'(err), 32'(m_err));
         chk("xfer_cnt", 32'(cnt), 32'(m_cnt));
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rt_cross_clk_arb.md
Name: rt_cross_clk_arb

Overview:
Round-robin arbiter/sequencer that shares one data-enable clock-crossing channel among NREQ requesters in the A clock domain. It accepts level requests with per-requester data and issues one single-cycle data-enable per transfer to the crossing channel. It then waits for the channel's busy round-trip to complete before granting again. Each transfer is tagged with the source index, a timeout watchdog guards against a stuck busy, and a transfer counter is provided.

Parameters:
NREQ, 4, number of requesters (2..16)
DWIDTH, 8, payload width per requester
TAGW, 2, index tag width; must be >= clog2(NREQ)
TMO_CYC, 1024, WAIT-state cycles before timeout error (>= 4)
CNTW, 16, transfer counter width

Ports:
rt_i_aclk  in  1  A-domain clock
rt_i_rst_aclk  in  1  synchronous active-high reset
rt_i_req_aclk  in  NREQ  per-requester request level
rt_i_din_aclk  in  NREQ*DWIDTH  packed payloads; requester i uses bits [i*DWIDTH +: DWIDTH]
rt_o_ack_aclk  out  NREQ  one-cycle pulse: payload of requester i taken
rt_o_de_aclk  out  1  data-enable to crossing channel
rt_o_din_aclk  out  TAGW+DWIDTH  {tag, payload} to crossing channel
rt_i_busy_aclk  in  1  crossing channel busy
rt_i_err_clr_aclk  in  1  clears sticky timeout error
rt_o_err_aclk  out  1  sticky timeout error
rt_o_xfer_cnt_aclk  out  CNTW  completed-issue counter

Behaviour:
- All outputs are registered. Reset values: ack=0, de=0, din=0, err=0, xfer_cnt=0, state=IDLE, RR pointer=NREQ-1, so requester 0 has first priority.
- Reset applies on any cycle, including mid-WAIT. The transfer in flight is abandoned and no ack is reissued.
- States: IDLE, SENT, WAIT.
- IDLE: if any req bit is set and busy=0, select the winner round-robin. Search starts at pointer+1 and wraps modulo NREQ. On the next edge:
  - de=1;
  - din={winner index zero-extended to TAGW, payload[winner]};
  - ack[winner]=1;
  - pointer=winner;
  - xfer_cnt+1, wrapping at 2^CNTW;
  - state=SENT.
- IDLE with busy=1: no issue, stay IDLE. This covers a channel still busy after a timeout.
- Latency: the request sampled in an IDLE cycle produces de and ack one cycle later.
- de and ack are strictly one cycle wide. din holds its value until the next issue.
- SENT: lasts exactly one cycle. de returns to 0 and state=WAIT. The channel raises busy in this cycle; the arbiter ignores busy here.
- WAIT: when busy=0, go to IDLE. Minimum spacing between de pulses is 3 cycles (SENT, WAIT, IDLE).
- WAIT timeout: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TMO_CYC-1 with busy still 1:
  - err is set;
  - state=IDLE;
  - nothing is issued until busy=0.
- err is sticky and cleared only by err_clr or reset. If set and clear occur in the same cycle, set wins.
- Requester contract: hold req and payload stable until ack. Deassert in the cycle after ack, or keep req high to request again. A req dropped before grant is simply never served, with no error.
- Fairness: with all NREQ requesting continuously, grants go 0,1,…,NREQ-1,0,…
- Non-requesting indices are skipped within the same cycle, with no idle slot.

Test Plan:
- Reset, then req=0001, din0=0xA5, busy pulses high for 5 cycles starting the cycle after de → de one cycle after req; din_out={2'd0,0xA5}; ack=0001 aligned with de; no second de until busy falls; xfer_cnt=1.
- req=1111 held, busy model 4-cycle round-trip → grant tags 0,1,2,3,0,1 in order; de spacing >= 3 cycles; each ack matches its tag.
- req=1010, pointer after grant 1 → next grant 3, then 1; indices 0 and 2 never acked.
- busy held high after a de, TMO_CYC=8 → err=1 after 8 WAIT cycles; no new de while busy=1; de resumes once busy=0; err stays 1 until err_clr.
- Reset asserted 2 cycles into WAIT with req=0100 pending → next grant goes to index 0 if requesting (pointer reset), otherwise 2; err=0; xfer_cnt=0.
- CNTW=4, 17 transfers → xfer_cnt wraps to 1; err_clr and a timeout in the same cycle → err stays 1.
